// File: rtl/hdmi_pll_ctrl.sv
//----------------------------------------------------------------------------
// hdmi_pll_ctrl: rPLL mode table, reset/lock sequencing, lock supervisor.
// Optional 2-flop LOCK synchroniser: define HDMI_PLL_CTRL_LOCK_SYNC_EN.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none
module hdmi_pll_ctrl #(
  parameter int          NUM_MODES        = 4,
  parameter int          DEFAULT_MODE     = 0,
  parameter logic [23:0] IDSEL_TBL        = 24'h0,
  parameter logic [23:0] FBDSEL_TBL       = 24'h0,
  parameter logic [23:0] ODSEL_TBL        = 24'h0,
  parameter int          RESET_HOLD_CYC   = 64,
  parameter int          LOCK_STABLE_CYC  = 1024,
  parameter int          LOCK_TIMEOUT_CYC = 500000,
  parameter int          MAX_RETRY        = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       mode_req_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic [1:0] mode_cur,
  output logic       locked,
  output logic       video_rst,
  output logic       bad_mode,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int HOLD_W = $clog2(RESET_HOLD_CYC + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYC + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST      = HOLD_W'(RESET_HOLD_CYC - 1);
  localparam logic [STAB_W-1:0] STAB_LAST      = STAB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST       = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [2:0]        NUM_MODES_L    = 3'(NUM_MODES);
  localparam logic [2:0]        MAX_RETRY_L    = (MAX_RETRY > 7) ? 3'd7 : 3'(MAX_RETRY);
  localparam logic [1:0]        DEFAULT_MODE_L = 2'(DEFAULT_MODE);

  state_t              state_q;
  state_t              state_d;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STAB_W-1:0]   stab_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [1:0]          mode_d;
  logic [1:0]          retry_d;
  logic [2:0]          retry_inc;
  logic                bad_d;
  logic                fail;
  logic                tmo_hit;
  logic                req_acc;
  logic                req_oob;
  logic                lock_s;

`ifdef HDMI_PLL_CTRL_LOCK_SYNC_EN
  logic [1:0] lock_sync;

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
    end
  end

  assign lock_s = lock_sync[1];
`else
  assign lock_s = pll_lock;
`endif

  function automatic logic [5:0] pick(input logic [23:0] tbl, input logic [1:0] m);
    case (m)
      2'd0:    pick = tbl[5:0];
      2'd1:    pick = tbl[11:6];
      2'd2:    pick = tbl[17:12];
      default: pick = tbl[23:18];
    endcase
  endfunction

  function automatic logic in_lock_phase(input state_t s);
    in_lock_phase = (s == S_WAIT_LOCK) || (s == S_STABLE);
  endfunction

  assign mode_req_ready = (state_q == S_RUN) || (state_q == S_FAULT);
  assign req_acc        = mode_req_valid && mode_req_ready;
  assign req_oob        = {1'b0, mode_req} >= NUM_MODES_L;
  assign tmo_hit        = (tmo_cnt == TMO_LAST);
  assign retry_inc      = {1'b0, retry_cnt} + 3'd1;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_cur;
    retry_d = retry_cnt;
    bad_d   = 1'b0;
    fail    = 1'b0;

    case (state_q)
      S_RESET_PLL: begin
        if (hold_cnt == HOLD_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (tmo_hit)     fail    = 1'b1;
        else if (lock_s) state_d = S_STABLE;
      end
      S_STABLE: begin
        // A lock that completes on the timeout cycle still counts as a success.
        if (lock_s && (stab_cnt == STAB_LAST)) begin
          state_d = S_RUN;
          retry_d = 2'd0;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end else if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_RUN: begin
        retry_d = 2'd0;
        if (!lock_s) state_d = S_RESET_PLL;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_RESET_PLL;
    endcase

    if (fail) begin
      retry_d = (retry_cnt == 2'd3) ? 2'd3 : retry_inc[1:0];
      state_d = (retry_inc < MAX_RETRY_L) ? S_RESET_PLL : S_FAULT;
    end

    if (req_acc) begin
      if (req_oob) begin
        bad_d = 1'b1;
      end else if (!((state_q == S_RUN) && (mode_req == mode_cur))) begin
        mode_d  = mode_req;
        state_d = S_RESET_PLL;
        retry_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= S_RESET_PLL;
      mode_cur  <= DEFAULT_MODE_L;
      idsel     <= pick(IDSEL_TBL, DEFAULT_MODE_L);
      fbdsel    <= pick(FBDSEL_TBL, DEFAULT_MODE_L);
      odsel     <= pick(ODSEL_TBL, DEFAULT_MODE_L);
      retry_cnt <= 2'd0;
      bad_mode  <= 1'b0;
      hold_cnt  <= '0;
      stab_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      mode_cur  <= mode_d;
      // mode_d only moves together with a RESET_PLL entry, so selects never change under a running PLL.
      idsel     <= pick(IDSEL_TBL, mode_d);
      fbdsel    <= pick(FBDSEL_TBL, mode_d);
      odsel     <= pick(ODSEL_TBL, mode_d);
      retry_cnt <= retry_d;
      bad_mode  <= bad_d;
      hold_cnt  <= ((state_q == S_RESET_PLL) && (state_d == S_RESET_PLL)) ? hold_cnt + HOLD_W'(1) : '0;
      stab_cnt  <= ((state_q == S_STABLE) && (state_d == S_STABLE)) ? stab_cnt + STAB_W'(1) : '0;
      // The timeout spans the whole WAIT_LOCK/STABLE attempt, not each sub-state.
      tmo_cnt   <= (in_lock_phase(state_q) && in_lock_phase(state_d)) ? tmo_cnt + TMO_W'(1) : '0;
    end
  end

  assign pll_reset = (state_q == S_RESET_PLL) || (state_q == S_FAULT);
  assign locked    = (state_q == S_RUN);
  assign video_rst = !locked;
  assign fault     = (state_q == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pll_ctrl.sv
//----------------------------------------------------------------------------
// tb_hdmi_pll_ctrl: scoreboard bench for hdmi_pll_ctrl sequencing and requests.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none
module tb_hdmi_pll_ctrl;

  localparam int HOLD   = 4;
  localparam int STAB   = 8;
  localparam int TMO    = 32;
  localparam int MAXR   = 2;
  localparam int NMODES = 3;
`ifdef HDMI_PLL_CTRL_LOCK_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  localparam logic [5:0] ID_A [4] = '{6'd10, 6'd11, 6'd12, 6'd13};
  localparam logic [5:0] FB_A [4] = '{6'd20, 6'd21, 6'd22, 6'd23};
  localparam logic [5:0] OD_A [4] = '{6'd30, 6'd31, 6'd32, 6'd33};

  localparam int ST_RP  = 0;
  localparam int ST_WL  = 1;
  localparam int ST_RUN = 3;
  localparam int ST_FLT = 4;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode_req = 2'd0;
  logic       mode_req_valid = 1'b0;
  logic       pll_lock = 1'b0;
  logic       mode_req_ready, pll_reset, locked, video_rst, bad_mode, fault;
  logic [5:0] idsel, fbdsel, odsel;
  logic [1:0] mode_cur, retry_cnt;

  hdmi_pll_ctrl #(
    .NUM_MODES(NMODES), .DEFAULT_MODE(0),
    .IDSEL_TBL({6'd13, 6'd12, 6'd11, 6'd10}),
    .FBDSEL_TBL({6'd23, 6'd22, 6'd21, 6'd20}),
    .ODSEL_TBL({6'd33, 6'd32, 6'd31, 6'd30}),
    .RESET_HOLD_CYC(HOLD), .LOCK_STABLE_CYC(STAB),
    .LOCK_TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clkin(clkin), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_req_ready(mode_req_ready), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel), .mode_cur(mode_cur),
    .locked(locked), .video_rst(video_rst), .bad_mode(bad_mode), .fault(fault),
    .retry_cnt(retry_cnt)
  );

  always #5 clkin = ~clkin;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    logic [27:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic [27:0] obs;
  assign obs = {mode_req_ready, pll_reset, locked, video_rst, bad_mode, fault,
                retry_cnt, mode_cur, idsel, fbdsel, odsel};

  // Expected output vector for an externally visible state, mode, retry count and bad_mode.
  function automatic logic [27:0] ev(input int st, input logic [1:0] m, input logic [1:0] r, input logic bad);
    logic rdy, pr, lk, flt;
    rdy = (st == ST_RUN) || (st == ST_FLT);
    pr  = (st == ST_RP) || (st == ST_FLT);
    lk  = (st == ST_RUN);
    flt = (st == ST_FLT);
    return {rdy, pr, lk, ~lk, bad, flt, r, m, ID_A[m], FB_A[m], OD_A[m]};
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic count_until(input logic want, input int limit, output int n);
    n = 0;
    while (locked !== want) begin
      if (n >= limit) begin
        n = -1;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic request(input logic [1:0] m);
    mode_req       = m;
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; pll_lock = 1'b0; mode_req_valid = 1'b0;
    repeat (3) tick();
    sb.push_back('{0, ev(ST_RP, 2'd0, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL reset_state: got %h expected %h", obs, e.v); end
    reset = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pll_reset) n++;
      else break;
    end
    tests++;
    if (n !== HOLD) begin fails++; $display("FAIL pll_reset_hold: got %0d cycles expected %0d", n, HOLD); end
  endtask

  task automatic test_lock_late();
    int n;
    tick(); tick();
    pll_lock = 1'b1;
    count_until(1'b1, 100, n);
    tests++;
    if (n !== SYNC + 1 + STAB) begin fails++; $display("FAIL lock_latency: got %0d expected %0d", n, SYNC + 1 + STAB); end
    sb.push_back('{0, ev(ST_RUN, 2'd0, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL run_mode0: got %h expected %h", obs, e.v); end
  endtask

  task automatic test_min_latency();
    int n;
    reset = 1'b1; pll_lock = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    count_until(1'b1, 200, n);
    tests++;
    if (n !== HOLD + 1 + STAB) begin fails++; $display("FAIL min_latency: got %0d expected %0d", n, HOLD + 1 + STAB); end
  endtask

  task automatic test_mode_switch();
    int n;
    request(2'd2);
    sb.push_back('{0, ev(ST_RP, 2'd2, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL switch_to_2: got %h expected %h", obs, e.v); end
    count_until(1'b1, 200, n);
    tests++;
    if (n !== HOLD + 1 + STAB) begin fails++; $display("FAIL relock_2: got %0d expected %0d", n, HOLD + 1 + STAB); end
    sb.push_back('{0, ev(ST_RUN, 2'd2, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL run_mode2: got %h expected %h", obs, e.v); end
  endtask

  task automatic test_bad_mode();
    request(2'd3);
    sb.push_back('{0, ev(ST_RUN, 2'd2, 2'd0, 1'b1)});
    sb.push_back('{1, ev(ST_RUN, 2'd2, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL bad_mode_pulse: got %h expected %h", obs, e.v); end
    tick();
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL bad_mode_clear: got %h expected %h", obs, e.v); end
    request(2'd2);
    sb.push_back('{0, ev(ST_RUN, 2'd2, 2'd0, 1'b0)});
    sb.push_back('{1, ev(ST_RUN, 2'd2, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL same_mode_noop: got %h expected %h", obs, e.v); end
    tick();
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL same_mode_stays: got %h expected %h", obs, e.v); end
  endtask

  task automatic test_lock_drop();
    int n;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 1;
    while (locked && n < 20) begin tick(); n++; end
    tests++;
    if (n !== SYNC + 1) begin fails++; $display("FAIL drop_latency: got %0d expected %0d", n, SYNC + 1); end
    sb.push_back('{0, ev(ST_RP, 2'd2, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL drop_resequence: got %h expected %h", obs, e.v); end
    request(2'd1);
    sb.push_back('{0, ev(ST_RP, 2'd2, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL ignored_when_busy: got %h expected %h", obs, e.v); end
    count_until(1'b1, 200, n);
    tests++;
    if (n !== HOLD + STAB) begin fails++; $display("FAIL relock_after_drop: got %0d expected %0d", n, HOLD + STAB); end
    sb.push_back('{0, ev(ST_RUN, 2'd2, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL run_after_drop: got %h expected %h", obs, e.v); end
  endtask

  task automatic test_timeout_fault();
    int seen;
    int n;
    request(2'd1);
    // Attempt: HOLD cycles of reset, then TMO cycles of lock wait before the failure edge.
    sb.push_back('{HOLD + TMO - 1,       ev(ST_WL,  2'd1, 2'd0, 1'b0)});
    sb.push_back('{HOLD + TMO,           ev(ST_RP,  2'd1, 2'd1, 1'b0)});
    sb.push_back('{2 * HOLD + TMO - 1,   ev(ST_RP,  2'd1, 2'd1, 1'b0)});
    sb.push_back('{2 * HOLD + TMO,       ev(ST_WL,  2'd1, 2'd1, 1'b0)});
    sb.push_back('{2 * (HOLD + TMO) - 1, ev(ST_WL,  2'd1, 2'd1, 1'b0)});
    sb.push_back('{2 * (HOLD + TMO),     ev(ST_FLT, 2'd1, 2'd2, 1'b0)});
    sb.push_back('{2 * (HOLD + TMO) + 8, ev(ST_FLT, 2'd1, 2'd2, 1'b0)});
    seen = 0;
    for (int c = 0; c <= 2 * (HOLD + TMO) + 8; c++) begin
      pll_lock = ((c / 5) % 2 == 0);
      if (locked) seen++;
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin fails++; $display("FAIL timeout_c%0d: got %h expected %h", c, obs, e.v); end
      end
      if (c < 2 * (HOLD + TMO) + 8) tick();
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL never_locked: got %0d locked cycles expected 0", seen); end
    pll_lock = 1'b1;
    request(2'd0);
    sb.push_back('{0, ev(ST_RP, 2'd0, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL fault_exit: got %h expected %h", obs, e.v); end
    count_until(1'b1, 200, n);
    tests++;
    if (n !== HOLD + 1 + STAB) begin fails++; $display("FAIL relock_after_fault: got %0d expected %0d", n, HOLD + 1 + STAB); end
  endtask

  task automatic test_reset_mid_stable();
    request(2'd2);
    repeat (HOLD + 3) tick();
    sb.push_back('{0, ev(ST_WL, 2'd2, 2'd0, 1'b0)});
    sb.push_back('{1, ev(ST_RP, 2'd0, 2'd0, 1'b0)});
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL mid_stable: got %h expected %h", obs, e.v); end
    reset = 1'b1;
    tick();
    e = sb.pop_front(); tests++;
    if (obs !== e.v) begin fails++; $display("FAIL reset_mid_stable: got %h expected %h", obs, e.v); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_lock_late();
    test_min_latency();
    test_mode_switch();
    test_bad_mode();
    test_lock_drop();
    test_timeout_fault();
    test_reset_mid_stable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
